odu_cfg_regbank: RTL and testbench
==================================

# odu_cfg_regbank

Parametrised configuration and control register bank for the ODU data generator. Holds the per-channel enable and type bitmaps in shadow registers and commits them atomically to the generator. Runs a start/stop handshake FSM with timeout supervision and exposes sticky status and a start counter over the same chip-select/write-enable/output-enable configuration bus used by the existing ODU config blocks. It sits between the host configuration port and the data generator core.

## Interface
- DATA_WIDTH_CFG, 16: bus data width (DW).
- ADDR_WIDTH_CFG, 6: bus address width; must cover address 2·N_W+3.
- NUM_CH, 80: channel count; N_W = ceil(NUM_CH/DW) words per bitmap.
- TIMEOUT, 1024: max cycles from gen_start to gen_active, ≥2.
- VERSION, 16'h0201: value returned at address 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_n_cs  in  1  chip select, active-low
- cfg_n_we  in  1  write strobe, active-low
- cfg_n_oe  in  1  read strobe, active-low
- cfg_addr  in  ADDR_WIDTH_CFG  word address
- cfg_din  in  DW  write data
- cfg_dout  out  DW  registered read data
- cfg_rvalid  out  1  one-cycle pulse, cfg_dout valid
- cfg_ch_enable  out  NUM_CH  committed enable bitmap, bit i = channel i
- cfg_ch_type  out  NUM_CH  committed type bitmap (0 = type 0, 1 = type 2)
- gen_start  out  1  one-cycle start pulse to generator
- gen_stop  out  1  one-cycle stop pulse to generator
- gen_active  in  1  generator running
- irq  out  1  OR of unmasked sticky status bits, registered

## Operation
- Address map, with C = 2·N_W+1:
  - 0: VERSION, read-only.
  - 1..N_W: enable shadow words; word k holds channels (k-1)·DW and up.
  - N_W+1..2·N_W: type shadow words, same layout.
  - C: control, write-only. Bit0 start, bit1 stop, bit2 commit. Reads 0.
  - C+1: status. Bit0 gen_active live. Bits 1–3 sticky, write-1-to-clear: bit1 done, bit2 timeout, bit3 cmd_reject. Bits5:4 FSM state. Bits 10:8 irq mask for bits 3:1, read/write.
  - C+2: start counter, DW bits, wraps. Any write clears it to 0.
  - Any other address reads 0; writes to it are ignored.
- Bitmap storage:
  - Bits ≥ NUM_CH in the last word are not stored and read as 0.
  - Shadow readback returns the shadow value, not the committed value.
- Commit copies all shadow words to cfg_ch_enable/cfg_ch_type in a single cycle. Commit occurs on an accepted start, or on a commit command while in IDLE.
- FSM states: IDLE=0, WAIT_ACT=1, RUN=2, STOPPING=3.
  - IDLE + start: commit, pulse gen_start, increment counter, load timer, go to WAIT_ACT.
  - WAIT_ACT + gen_active=1: go to RUN.
  - WAIT_ACT + timer expires (TIMEOUT cycles with gen_active=0): set timeout, go to IDLE.
  - WAIT_ACT + stop: pulse gen_stop, go to STOPPING.
  - RUN + stop: pulse gen_stop, go to STOPPING.
  - RUN + gen_active falls: set done, go to IDLE.
  - STOPPING + gen_active=0: set done, go to IDLE. There is no timeout in STOPPING.
- Command rules:
  - Start outside IDLE is rejected: set cmd_reject, no other effect.
  - Commit outside IDLE is rejected: set cmd_reject, no other effect.
  - Stop in IDLE is a silent no-op.
  - When several control bits are written together, they are processed with priority stop > start > commit. The lower-priority bits are discarded and do not set cmd_reject.
- A sticky set event in the same cycle as a W1C write to that bit leaves the bit set.

## Timing
- Write: accepted when cs=0 and we=0; the register updates at the next edge.
- Read: accepted when cs=0 and oe=0. cfg_dout and cfg_rvalid are asserted the following cycle. cfg_dout holds its value until the next read.
- Write and read in the same cycle: the write is performed and the read returns the pre-write value.
- Control commands act at the edge after the write. gen_start, the counter increment and the committed outputs all change on that same edge.
- gen_active is sampled directly with no synchroniser; the generator shares clk.
- irq follows the sticky/mask state with one cycle of lag.
- Reset: all registers, bitmaps, counter, timer, cfg_dout, cfg_rvalid, gen_start, gen_stop and irq go to 0; FSM goes to IDLE.
  - Reset during RUN issues no gen_stop; the generator is reset by the same rst.

## Test plan
- Defaults NUM_CH=80, DW=16 (C=11):
  - Read addr 0 → 16'h0201.
  - Write addr 5 = 16'hFFFF → read back 16'hFFFF.
  - Addresses 14 and 63 → read 0.
- Write enable word 1 = 16'h00F0, then write 1 to addr 11:
  - gen_start pulses for exactly one cycle.
  - cfg_ch_enable[7:4] = 4'hF on that same edge.
  - Addr 13 reads 1.
- Hold gen_active=0 after start:
  - Status bit2 sets after 1024 cycles and the state reads 0.
  - Write 16'h0004 to addr 12 → bit2 clears.
- Start, drive gen_active=1, then write 2 to addr 11:
  - gen_stop pulses once.
  - Drop gen_active → done bit set.
  - irq=1 only if mask bit8 is set.
- Write start and commit while in RUN → cmd_reject set; bitmaps and counter unchanged.
- Assert rst mid-RUN → all outputs 0, state IDLE, and no gen_stop.

Source files
------------

// File: rtl/odu_cfg_regbank.sv
// odu_cfg_regbank: host-facing configuration/control register bank for the ODU data generator.
// Shadow enable/type bitmaps commit atomically. A start/stop FSM with timeout supervision drives the generator.
// Sticky status, irq masking and a start counter are exposed on the cs/we/oe config bus.
// Ports: clk/rst (sync, active-high); cfg_n_cs/cfg_n_we/cfg_n_oe/cfg_addr/cfg_din in, cfg_dout/cfg_rvalid out;
//        cfg_ch_enable/cfg_ch_type committed bitmaps; gen_start/gen_stop pulses, gen_active in; irq out.
module odu_cfg_regbank #(
  parameter int DATA_WIDTH_CFG = 16,
  parameter int ADDR_WIDTH_CFG = 6,
  parameter int NUM_CH         = 80,
  parameter int TIMEOUT        = 1024,
  parameter logic [DATA_WIDTH_CFG-1:0] VERSION = 16'h0201
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_n_cs,
  input  logic                      cfg_n_we,
  input  logic                      cfg_n_oe,
  input  logic [ADDR_WIDTH_CFG-1:0] cfg_addr,
  input  logic [DATA_WIDTH_CFG-1:0] cfg_din,
  output logic [DATA_WIDTH_CFG-1:0] cfg_dout,
  output logic                      cfg_rvalid,
  output logic [NUM_CH-1:0]         cfg_ch_enable,
  output logic [NUM_CH-1:0]         cfg_ch_type,
  output logic                      gen_start,
  output logic                      gen_stop,
  input  logic                      gen_active,
  output logic                      irq
);

  localparam int DW   = DATA_WIDTH_CFG;
  localparam int AW   = ADDR_WIDTH_CFG;
  localparam int N_W  = (NUM_CH + DW - 1) / DW;
  localparam int PADW = N_W * DW;
  localparam int TW   = $clog2(TIMEOUT);

  localparam logic [AW-1:0] A_VER  = '0;
  localparam logic [AW-1:0] A_CTRL = AW'(2 * N_W + 1);
  localparam logic [AW-1:0] A_STAT = AW'(2 * N_W + 2);
  localparam logic [AW-1:0] A_CNT  = AW'(2 * N_W + 3);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACT = 2'd1,
    S_RUN      = 2'd2,
    S_STOPPING = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_CH-1:0]   en_sh_q, en_sh_d, ty_sh_q, ty_sh_d;
  logic [NUM_CH-1:0]   en_q, en_d, ty_q, ty_d;
  logic [2:0]          sticky_q, sticky_d;   // {cmd_reject, timeout, done}
  logic [2:0]          mask_q, mask_d;
  logic [DW-1:0]       cnt_q, cnt_d;
  logic                start_q, start_d, stop_q, stop_d;
  logic                irq_q;
  logic [DW-1:0]       dout_q, dout_d;
  logic                rvalid_q;

  logic                wr, rd, ctrl_wr;
  logic                cmd_start, cmd_stop, cmd_commit;
  logic                do_commit, set_done, set_to, set_rej, cnt_inc;
  logic [PADW-1:0]     en_pad, ty_pad;
  logic [DW-1:0]       stat_rd, rdata;

  assign wr      = ~cfg_n_cs & ~cfg_n_we;
  assign rd      = ~cfg_n_cs & ~cfg_n_oe;
  assign ctrl_wr = wr && (cfg_addr == A_CTRL);

  // Priority stop > start > commit: lower-priority bits are simply dropped.
  assign cmd_stop   = ctrl_wr & cfg_din[1];
  assign cmd_start  = ctrl_wr & cfg_din[0] & ~cfg_din[1];
  assign cmd_commit = ctrl_wr & cfg_din[2] & ~cfg_din[1] & ~cfg_din[0];

  // Start/commit are only legal in IDLE; stop is never rejected.
  assign set_rej = (cmd_start | cmd_commit) && (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    do_commit = 1'b0;
    set_done  = 1'b0;
    set_to    = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          do_commit = 1'b1;
          start_d   = 1'b1;
          cnt_inc   = 1'b1;
          timer_d   = T_LOAD;
          state_d   = S_WAIT_ACT;
        end else if (cmd_commit) begin
          do_commit = 1'b1;
        end
      end
      S_WAIT_ACT: begin
        if (cmd_stop) begin
          stop_d  = 1'b1;
          state_d = S_STOPPING;
        end else if (gen_active) begin
          state_d = S_RUN;
        end else if (timer_q == '0) begin
          // Timer was loaded with TIMEOUT-1, so this is the TIMEOUT-th idle cycle.
          set_to  = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_RUN: begin
        if (cmd_stop) begin
          stop_d  = 1'b1;
          state_d = S_STOPPING;
        end else if (!gen_active) begin
          set_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_STOPPING: begin
        if (!gen_active) begin
          set_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Zero-padded views so partial last words read back 0 above NUM_CH.
  always_comb begin
    en_pad = '0;
    ty_pad = '0;
    en_pad[NUM_CH-1:0] = en_sh_q;
    ty_pad[NUM_CH-1:0] = ty_sh_q;
  end

  always_comb begin
    stat_rd       = '0;
    stat_rd[0]    = gen_active;
    stat_rd[3:1]  = sticky_q;
    stat_rd[5:4]  = state_q;
    stat_rd[10:8] = mask_q;
  end

  // Read mux uses pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    rdata = '0;
    if (cfg_addr == A_VER)  rdata = VERSION;
    if (cfg_addr == A_STAT) rdata = stat_rd;
    if (cfg_addr == A_CNT)  rdata = cnt_q;
    for (int k = 0; k < N_W; k++) begin
      if (cfg_addr == AW'(k + 1))       rdata = en_pad[k*DW +: DW];
      if (cfg_addr == AW'(N_W + k + 1)) rdata = ty_pad[k*DW +: DW];
    end
  end

  always_comb begin
    en_sh_d  = en_sh_q;
    ty_sh_d  = ty_sh_q;
    en_d     = en_q;
    ty_d     = ty_q;
    sticky_d = sticky_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;

    for (int i = 0; i < NUM_CH; i++) begin
      if (wr && (cfg_addr == AW'(i / DW + 1)))       en_sh_d[i] = cfg_din[i % DW];
      if (wr && (cfg_addr == AW'(N_W + i / DW + 1))) ty_sh_d[i] = cfg_din[i % DW];
    end

    if (do_commit) begin
      en_d = en_sh_q;
      ty_d = ty_sh_q;
    end

    if (wr && (cfg_addr == A_STAT)) begin
      sticky_d = sticky_q & ~cfg_din[3:1];
      mask_d   = cfg_din[10:8];
    end
    // Set events are applied after the W1C clear so they win.
    sticky_d = sticky_d | {set_rej, set_to, set_done};

    if (wr && (cfg_addr == A_CNT)) cnt_d = '0;
    else if (cnt_inc)              cnt_d = cnt_q + 1'b1;

    if (rd) dout_d = rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      en_sh_q  <= '0;
      ty_sh_q  <= '0;
      en_q     <= '0;
      ty_q     <= '0;
      sticky_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      irq_q    <= 1'b0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      en_sh_q  <= en_sh_d;
      ty_sh_q  <= ty_sh_d;
      en_q     <= en_d;
      ty_q     <= ty_d;
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      irq_q    <= |(sticky_q & mask_q);
      dout_q   <= dout_d;
      rvalid_q <= rd;
    end
  end

  assign cfg_dout      = dout_q;
  assign cfg_rvalid    = rvalid_q;
  assign cfg_ch_enable = en_q;
  assign cfg_ch_type   = ty_q;
  assign gen_start     = start_q;
  assign gen_stop      = stop_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_odu_cfg_regbank.sv
module tb_odu_cfg_regbank;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_n_cs, cfg_n_we, cfg_n_oe;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_din;
  logic [15:0] cfg_dout;
  logic        cfg_rvalid;
  logic [79:0] cfg_ch_enable, cfg_ch_type;
  logic        gen_start, gen_stop, gen_active, irq;

  odu_cfg_regbank dut (
    .clk(clk), .rst(rst),
    .cfg_n_cs(cfg_n_cs), .cfg_n_we(cfg_n_we), .cfg_n_oe(cfg_n_oe),
    .cfg_addr(cfg_addr), .cfg_din(cfg_din),
    .cfg_dout(cfg_dout), .cfg_rvalid(cfg_rvalid),
    .cfg_ch_enable(cfg_ch_enable), .cfg_ch_type(cfg_ch_type),
    .gen_start(gen_start), .gen_stop(gen_stop),
    .gen_active(gen_active), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] exp;
    logic [5:0]  addr;
  } sb_t;

  sb_t         sb_q[$];
  vec_t        vecs[11];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [79:0] exp_sh_en = '0;
  logic [79:0] exp_sh_ty = '0;
  logic [79:0] exp_en = '0;
  logic [79:0] exp_ty = '0;
  logic        stop_seen;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference shadow model: word k of a bitmap holds channels (k-1)*16 upward.
  task automatic model_write(input logic [5:0] addr, input logic [15:0] din);
    int a;
    a = int'(addr);
    if (a >= 1 && a <= 5)       exp_sh_en[(a-1)*16 +: 16] = din;
    else if (a >= 6 && a <= 10) exp_sh_ty[(a-6)*16 +: 16] = din;
  endtask

  // One bus cycle; reads push their expectation and pop it when cfg_rvalid appears.
  task automatic acc(input logic we, input logic rd, input logic [5:0] addr,
                     input logic [15:0] din, input logic [15:0] exp);
    sb_t e;
    int  waitc;
    @(negedge clk);
    cfg_n_cs = 1'b0;
    cfg_n_we = ~we;
    cfg_n_oe = ~rd;
    cfg_addr = addr;
    cfg_din  = din;
    if (rd) begin
      e.exp  = exp;
      e.addr = addr;
      sb_q.push_back(e);
    end
    if (we) model_write(addr, din);
    @(negedge clk);
    cfg_n_cs = 1'b1;
    cfg_n_we = 1'b1;
    cfg_n_oe = 1'b1;
    if (rd) begin
      waitc = 0;
      while (!cfg_rvalid && waitc < 4) begin
        @(negedge clk);
        waitc++;
      end
      e = sb_q.pop_front();
      if (!cfg_rvalid) begin
        n_cmp++;
        n_err++;
        $display("FAIL rvalid_timeout addr %0d: no cfg_rvalid, expected data %h", e.addr, e.exp);
      end else begin
        chk($sformatf("read_addr_%0d", e.addr), {64'd0, cfg_dout}, {64'd0, e.exp});
      end
    end
  endtask

  task automatic rd_chk(input logic [5:0] addr, input logic [15:0] exp);
    acc(1'b0, 1'b1, addr, 16'h0000, exp);
  endtask

  task automatic wr(input logic [5:0] addr, input logic [15:0] din);
    acc(1'b1, 1'b0, addr, din, 16'h0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{we: 1'b0, addr: 6'd0,  din: 16'h0000, exp: 16'h0201};
    vecs[1]  = '{we: 1'b1, addr: 6'd0,  din: 16'h1234, exp: 16'h0201};
    vecs[2]  = '{we: 1'b1, addr: 6'd5,  din: 16'hFFFF, exp: 16'hFFFF};
    vecs[3]  = '{we: 1'b1, addr: 6'd1,  din: 16'h00F0, exp: 16'h00F0};
    vecs[4]  = '{we: 1'b1, addr: 6'd10, din: 16'hFFFF, exp: 16'hFFFF};
    vecs[5]  = '{we: 1'b1, addr: 6'd7,  din: 16'hA5A5, exp: 16'hA5A5};
    vecs[6]  = '{we: 1'b1, addr: 6'd14, din: 16'h1234, exp: 16'h0000};
    vecs[7]  = '{we: 1'b0, addr: 6'd63, din: 16'h0000, exp: 16'h0000};
    vecs[8]  = '{we: 1'b1, addr: 6'd11, din: 16'h0000, exp: 16'h0000};
    vecs[9]  = '{we: 1'b0, addr: 6'd13, din: 16'h0000, exp: 16'h0000};
    vecs[10] = '{we: 1'b0, addr: 6'd12, din: 16'h0000, exp: 16'h0000};

    rst = 1'b1;
    cfg_n_cs = 1'b1; cfg_n_we = 1'b1; cfg_n_oe = 1'b1;
    cfg_addr = '0; cfg_din = '0; gen_active = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", {64'd0, cfg_dout}, 80'd0);
    chk("rst_rvalid", {79'd0, cfg_rvalid}, 80'd0);
    chk("rst_enable", cfg_ch_enable, 80'd0);
    chk("rst_type", cfg_ch_type, 80'd0);
    chk("rst_outs", {77'd0, gen_start, gen_stop, irq}, 80'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].din);
      rd_chk(vecs[i].addr, vecs[i].exp);
    end
    chk("enable_uncommitted", cfg_ch_enable, 80'd0);

    // Same-cycle write and read returns the old value.
    acc(1'b1, 1'b1, 6'd2, 16'h5555, 16'h0000);
    rd_chk(6'd2, 16'h5555);

    // Start with gen_active held low: commit + pulse, then timeout boundary.
    wr(6'd11, 16'h0001);
    exp_en = exp_sh_en;
    exp_ty = exp_sh_ty;
    chk("start_pulse", {79'd0, gen_start}, 80'd1);
    chk("start_enable", cfg_ch_enable, exp_en);
    chk("start_enable_7_4", {76'd0, cfg_ch_enable[7:4]}, 80'hF);
    chk("start_type", cfg_ch_type, exp_ty);
    @(negedge clk);
    chk("start_pulse_end", {79'd0, gen_start}, 80'd0);
    rd_chk(6'd13, 16'h0001);
    repeat (1018) @(negedge clk);
    rd_chk(6'd12, 16'h0010);
    rd_chk(6'd12, 16'h0004);
    wr(6'd12, 16'h0004);
    rd_chk(6'd12, 16'h0000);

    // Normal run and stop, then irq gating by mask bit 8.
    wr(6'd11, 16'h0001);
    @(negedge clk);
    gen_active = 1'b1;
    rd_chk(6'd12, 16'h0021);
    wr(6'd11, 16'h0002);
    chk("stop_pulse", {79'd0, gen_stop}, 80'd1);
    @(negedge clk);
    chk("stop_pulse_end", {79'd0, gen_stop}, 80'd0);
    rd_chk(6'd12, 16'h0031);
    @(negedge clk);
    gen_active = 1'b0;
    rd_chk(6'd12, 16'h0002);
    chk("irq_masked", {79'd0, irq}, 80'd0);
    wr(6'd12, 16'h0100);
    chk("irq_lag", {79'd0, irq}, 80'd0);
    @(negedge clk);
    chk("irq_unmasked", {79'd0, irq}, 80'd1);
    wr(6'd12, 16'h0002);
    rd_chk(6'd12, 16'h0000);
    rd_chk(6'd13, 16'h0002);

    // Commands in RUN are rejected and leave bitmaps/counter alone.
    wr(6'd11, 16'h0001);
    @(negedge clk);
    gen_active = 1'b1;
    wr(6'd1, 16'hAAAA);
    wr(6'd11, 16'h0005);
    chk("reject_no_start", {79'd0, gen_start}, 80'd0);
    chk("reject_enable", cfg_ch_enable, exp_en);
    rd_chk(6'd12, 16'h0029);
    rd_chk(6'd13, 16'h0003);
    wr(6'd12, 16'h0008);
    wr(6'd11, 16'h0004);
    chk("reject_commit_enable", cfg_ch_enable, exp_en);
    rd_chk(6'd12, 16'h0029);
    wr(6'd12, 16'h0008);
    wr(6'd11, 16'h0003);
    chk("stop_over_start", {79'd0, gen_stop}, 80'd1);
    rd_chk(6'd12, 16'h0031);
    @(negedge clk);
    gen_active = 1'b0;
    rd_chk(6'd12, 16'h0002);

    // Commit in IDLE copies the new shadow without starting.
    wr(6'd11, 16'h0004);
    exp_en = exp_sh_en;
    chk("idle_commit_enable", cfg_ch_enable, exp_en);
    chk("idle_commit_no_start", {79'd0, gen_start}, 80'd0);
    rd_chk(6'd13, 16'h0003);

    // Reset in RUN with a pending irq.
    wr(6'd12, 16'h0702);
    wr(6'd11, 16'h0001);
    @(negedge clk);
    gen_active = 1'b1;
    rd_chk(6'd12, 16'h0721);
    wr(6'd11, 16'h0001);
    @(negedge clk);
    chk("irq_reject", {79'd0, irq}, 80'd1);
    stop_seen = 1'b0;
    rst = 1'b1;
    gen_active = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (gen_stop) stop_seen = 1'b1;
    end
    chk("rst_run_dout", {64'd0, cfg_dout}, 80'd0);
    chk("rst_run_enable", cfg_ch_enable, 80'd0);
    chk("rst_run_type", cfg_ch_type, 80'd0);
    chk("rst_run_outs", {77'd0, gen_start, gen_stop, irq}, 80'd0);
    rst = 1'b0;
    @(negedge clk);
    if (gen_stop) stop_seen = 1'b1;
    chk("rst_no_stop", {79'd0, stop_seen}, 80'd0);
    rd_chk(6'd12, 16'h0000);
    rd_chk(6'd13, 16'h0000);
    rd_chk(6'd1, 16'h0000);

    chk("scoreboard_empty", 80'(sb_q.size()), 80'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
